// File: rtl/avg_fetch.sv
// avg_fetch: AVG instruction fetch stage, assembles byte-wide vector memory into 32-bit
// instructions, owns the PC and the JSR/RTS return stack.
module avg_fetch #(
   parameter int          STACK_DEPTH = 4,
   parameter logic [15:0] START_ADDR  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   output logic [15:0] vmemAddr,
   output logic        vmemRd,
   input  logic [7:0]  vmemData,
   output logic [31:0] inst,
   output logic        instValid,
   input  logic        instReady,
   input  logic [2:0]  pcOffset,
   input  logic        jmp,
   input  logic        jsr,
   input  logic        ret,
   input  logic        halt,
   input  logic [15:0] jumpAddr,
   output logic        halted,
   output logic        stackErr,
   output logic [15:0] pc
);
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

   typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, B4, VALID} state_t;
   state_t state, state_nxt;

   logic [SPW-1:0] sp;
   logic [15:0]    stack [STACK_DEPTH];
   logic [15:0]    next_pc;
   logic           xfer, call, jump, rtn, seq, full, empty, err;
   logic [IW-1:0]  wr_idx, rd_idx;

   // go wins over any transfer, so feedback is ignored in a go cycle
   assign xfer    = state == VALID && instReady && !go;
   assign call    = xfer && !halt && jmp && jsr;
   assign jump    = xfer && !halt && jmp && !jsr;
   assign rtn     = xfer && !halt && !jmp && ret;
   assign seq     = xfer && !halt && !jmp && !ret;
   assign full    = sp == SP_FULL;
   assign empty   = sp == '0;
   assign err     = (call && full) || (rtn && empty);
   assign next_pc = pc + {13'b0, pcOffset};
   assign wr_idx  = IW'(sp);
   assign rd_idx  = IW'(sp - 1'b1);

   assign vmemAddr  = pc + (state == B1 ? 16'd1 : state == B2 ? 16'd2 :
                            (state == B3 || state == B4) ? 16'd3 : 16'd0);
   assign vmemRd    = state == B0 || state == B1 || state == B2 || state == B3;
   assign instValid = state == VALID;
   assign halted    = state == IDLE;

   always_comb begin
      state_nxt = state;
      case (state)
         B0:      state_nxt = B1;
         B1:      state_nxt = B2;
         B2:      state_nxt = (vmemData[7:5] == 3'b000) ? B3 : VALID;
         B3:      state_nxt = B4;
         B4:      state_nxt = VALID;
         VALID:   state_nxt = !instReady ? VALID : (halt || err) ? IDLE : B0;
         default: state_nxt = state;
      endcase
      if (go) state_nxt = B0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= '0;
         sp       <= '0;
         stackErr <= 1'b0;
         inst     <= '0;
      end else begin
         state <= state_nxt;
         if (state == B1) inst[31:24] <= vmemData;
         if (state == B2) inst[23:16] <= vmemData;
         if (state == B2 && vmemData[7:5] != 3'b000) inst[15:0] <= '0;
         if (state == B3) inst[15:8] <= vmemData;
         if (state == B4) inst[7:0] <= vmemData;
         if (go) begin
            pc       <= START_ADDR;
            sp       <= '0;
            stackErr <= 1'b0;
         end else if (call && !full) begin
            pc <= jumpAddr;
            sp <= sp + 1'b1;
         end else if (jump) begin
            pc <= jumpAddr;
         end else if (rtn && !empty) begin
            pc <= stack[rd_idx];
            sp <= sp - 1'b1;
         end else if (seq) begin
            pc <= next_pc;
         end
         if (err) stackErr <= 1'b1;
      end
   end

   always_ff @(posedge clk)
      if (call && !full) stack[wr_idx] <= next_pc;
endmodule
